// File: rtl/node_input_fifo_pkg.sv
// Shared flit definitions for the mesh input buffer: flit type tags, header layout
// and the flit word carried on node links.
package node_input_fifo_pkg;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'b00,
        FLIT_BODY   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_RSVD   = 2'b11
    } flit_type_e;

    typedef struct packed {
        logic [3:0] dst_x;
        logic [3:0] dst_y;
        logic [7:0] pkt_id;
    } flit_hdr_t;

    typedef struct packed {
        flit_type_e  ftype;
        logic [15:0] payload;
    } flit_t;

    localparam int unsigned FLIT_W = $bits(flit_t);

    function automatic logic is_tail(input flit_t f);
        return f.ftype == FLIT_TAIL;
    endfunction

endpackage

// File: rtl/node_input_fifo_if.sv
// Link bundle between upstream sender, the input buffer and the node's down port,
// including the buffer's status outputs.
interface node_input_fifo_if
    import node_input_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic             in_enable;
    flit_t            in_flit;
    logic             in_ack;
    logic             out_enable;
    flit_t            out_flit;
    logic             out_ack;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W-1:0] pkt_count;
    logic             proto_err;

    modport slave (
        input  in_enable, in_flit, out_ack,
        output in_ack, out_enable, out_flit, occupancy, pkt_count, proto_err
    );

    modport master (
        output in_enable, in_flit, out_ack,
        input  in_ack, out_enable, out_flit, occupancy, pkt_count, proto_err
    );

endinterface

// File: rtl/node_input_fifo_mem.sv
// Flit storage array: one synchronous write port, one asynchronous read port.
// Holds no reset; validity is tracked entirely by the owner's pointers.
module flit_fifo_mem
    import node_input_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  flit_t         wdata_i,
    input  logic [AW-1:0] raddr_i,
    output flit_t         rdata_o
);

    flit_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/node_input_fifo.sv
// Per-port input buffer ahead of a mesh node: first-word fall-through FIFO with
// packet framing policing, buffered-packet count and a sticky protocol error flag.
module node_input_fifo
    import node_input_fifo_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    node_input_fifo_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_e;

    frame_state_e     state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic             err_q, err_d;

    logic  full, empty;
    logic  in_hs, push, pop;
    logic  push_tail, pop_tail;
    flit_t head_flit;

    assign full  = (occ_q == CNT_W'(DEPTH));
    assign empty = (occ_q == '0);

    // Handshake flags come from registered occupancy only, so a pop on a full
    // buffer cannot admit a new flit in the same cycle.
    assign bus.in_ack     = !full;
    assign bus.out_enable = !empty;
    assign bus.out_flit   = head_flit;
    assign bus.occupancy  = occ_q;
    assign bus.pkt_count  = pkt_q;
    assign bus.proto_err  = err_q;

    assign in_hs = bus.in_enable && !full;
    assign pop   = !empty && bus.out_ack;

    flit_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.in_flit),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_flit)
    );

    // Framing check: decides whether an accepted flit is stored or dropped.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_d   = err_q;
        if (in_hs) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_flit.ftype == FLIT_HEADER) begin
                        push    = 1'b1;
                        state_d = IN_PKT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (bus.in_flit.ftype == FLIT_BODY) begin
                        push = 1'b1;
                    end else if (bus.in_flit.ftype == FLIT_TAIL) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign push_tail = push && is_tail(bus.in_flit);
    assign pop_tail  = pop && is_tail(head_flit);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        occ_d = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + CNT_W'(1);
            2'b01:   occ_d = occ_q - CNT_W'(1);
            default: occ_d = occ_q;
        endcase

        pkt_d = pkt_q;
        unique case ({push_tail, pop_tail})
            2'b10:   pkt_d = pkt_q + CNT_W'(1);
            2'b01:   pkt_d = pkt_q - CNT_W'(1);
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            pkt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_node_input_fifo.sv
// Directed and randomized-stream checks for node_input_fifo with DEPTH=4.
module tb_node_input_fifo;
    import node_input_fifo_pkg::*;

    logic clk;
    logic rst;
    int unsigned total;
    int unsigned fails;

    node_input_fifo_if #(.DEPTH(4)) bus ();

    node_input_fifo #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic flit_t mk(input flit_type_e t, input logic [15:0] d);
        flit_t f;
        f.ftype   = t;
        f.payload = d;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    flit_t h1, b1, b2, t1, h2, t2, bx, h3, t3, h4, b4, b5;
    flit_t stream [$];
    flit_t sb [$];
    flit_t exp_f;
    int unsigned idx;
    int unsigned budget;
    int unsigned tails_q;
    logic do_push, do_pop;

    initial begin
        total = 0;
        fails = 0;
        h1 = mk(FLIT_HEADER, 16'h1101); b1 = mk(FLIT_BODY, 16'h1102);
        b2 = mk(FLIT_BODY,   16'h1103); t1 = mk(FLIT_TAIL, 16'h1104);
        h2 = mk(FLIT_HEADER, 16'h2201); t2 = mk(FLIT_TAIL, 16'h2202);
        bx = mk(FLIT_BODY,   16'h3301); h3 = mk(FLIT_HEADER, 16'h3302);
        t3 = mk(FLIT_TAIL,   16'h3303); h4 = mk(FLIT_HEADER, 16'h4401);
        b4 = mk(FLIT_BODY,   16'h4402); b5 = mk(FLIT_BODY, 16'h5501);

        rst = 1'b1;
        bus.in_enable = 1'b0;
        bus.in_flit   = '0;
        bus.out_ack   = 1'b0;
        cyc(); cyc();
        chk("rst_occ", 32'(bus.occupancy), 32'd0);
        chk("rst_pkt", 32'(bus.pkt_count), 32'd0);
        chk("rst_err", 32'(bus.proto_err), 32'd0);
        chk("rst_in_ack", 32'(bus.in_ack), 32'd1);
        chk("rst_out_en", 32'(bus.out_enable), 32'd0);
        rst = 1'b0;
        cyc();

        // Single packet flowing straight through
        bus.out_ack = 1'b1;
        bus.in_enable = 1'b1; bus.in_flit = h1;
        chk("t1_no_bypass", 32'(bus.out_enable), 32'd0);
        cyc();
        chk("t1_en_h", 32'(bus.out_enable), 32'd1);
        chk("t1_flit_h", 32'(bus.out_flit), 32'(h1));
        bus.in_flit = b1;
        cyc();
        chk("t1_occ_b", 32'(bus.occupancy), 32'd1);
        chk("t1_flit_b", 32'(bus.out_flit), 32'(b1));
        bus.in_flit = t1;
        cyc();
        chk("t1_flit_t", 32'(bus.out_flit), 32'(t1));
        chk("t1_pkt1", 32'(bus.pkt_count), 32'd1);
        bus.in_enable = 1'b0;
        cyc();
        chk("t1_pkt0", 32'(bus.pkt_count), 32'd0);
        chk("t1_empty", 32'(bus.out_enable), 32'd0);
        chk("t1_err", 32'(bus.proto_err), 32'd0);

        // Fill to DEPTH with the node stalled
        bus.out_ack = 1'b0;
        bus.in_enable = 1'b1;
        bus.in_flit = h1; cyc();
        bus.in_flit = b1; cyc();
        bus.in_flit = b2; cyc();
        bus.in_flit = t1; cyc();
        chk("t2_full_ack", 32'(bus.in_ack), 32'd0);
        chk("t2_occ4", 32'(bus.occupancy), 32'd4);
        chk("t2_pkt1", 32'(bus.pkt_count), 32'd1);
        bus.in_flit = h2;
        cyc();
        chk("t2_held", 32'(bus.occupancy), 32'd4);

        // Pop while full: the waiting flit is not admitted this cycle
        bus.out_ack = 1'b1;
        chk("t3_ack_low", 32'(bus.in_ack), 32'd0);
        chk("t3_head_h1", 32'(bus.out_flit), 32'(h1));
        cyc();
        chk("t3_occ3", 32'(bus.occupancy), 32'd3);
        chk("t3_head_b1", 32'(bus.out_flit), 32'(b1));
        chk("t3_ack_back", 32'(bus.in_ack), 32'd1);
        cyc();
        chk("t3_pushpop_occ", 32'(bus.occupancy), 32'd3);
        chk("t3_head_b2", 32'(bus.out_flit), 32'(b2));
        bus.in_enable = 1'b0;
        cyc();
        chk("t3_head_t1", 32'(bus.out_flit), 32'(t1));
        cyc();
        chk("t3_pkt0", 32'(bus.pkt_count), 32'd0);
        chk("t3_head_h2", 32'(bus.out_flit), 32'(h2));
        cyc();
        chk("t3_drained", 32'(bus.occupancy), 32'd0);
        bus.in_enable = 1'b1; bus.in_flit = t2;
        cyc();
        bus.in_enable = 1'b0;
        chk("t3_head_t2", 32'(bus.out_flit), 32'(t2));
        cyc();
        chk("t3_err0", 32'(bus.proto_err), 32'd0);

        // BODY while idle is dropped and flags an error
        bus.in_enable = 1'b1; bus.in_flit = bx;
        chk("t4_ack", 32'(bus.in_ack), 32'd1);
        cyc();
        chk("t4_err", 32'(bus.proto_err), 32'd1);
        chk("t4_occ0", 32'(bus.occupancy), 32'd0);
        chk("t4_no_out", 32'(bus.out_enable), 32'd0);
        bus.in_flit = h3;
        cyc();
        chk("t4_head_h3", 32'(bus.out_flit), 32'(h3));
        bus.in_flit = t3;
        cyc();
        chk("t4_head_t3", 32'(bus.out_flit), 32'(t3));
        bus.in_enable = 1'b0;
        cyc();
        chk("t4_occ_end", 32'(bus.occupancy), 32'd0);

        // Asynchronous reset mid-packet flushes everything
        bus.out_ack = 1'b0;
        bus.in_enable = 1'b1;
        bus.in_flit = h4; cyc();
        bus.in_flit = b4; cyc();
        bus.in_enable = 1'b0;
        chk("t5_occ2", 32'(bus.occupancy), 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("t5_async_occ", 32'(bus.occupancy), 32'd0);
        chk("t5_async_en", 32'(bus.out_enable), 32'd0);
        chk("t5_async_err", 32'(bus.proto_err), 32'd0);
        cyc();
        rst = 1'b0;
        bus.in_enable = 1'b1; bus.in_flit = b5;
        cyc();
        bus.in_enable = 1'b0;
        chk("t5_idle_err", 32'(bus.proto_err), 32'd1);
        chk("t5_idle_occ", 32'(bus.occupancy), 32'd0);

        // Random stream of 20 well-formed packets
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int p = 0; p < 20; p++) begin
            int unsigned len;
            len = $urandom_range(2, 5);
            stream.push_back(mk(FLIT_HEADER, 16'(p * 16)));
            for (int unsigned k = 1; k + 1 < len; k++)
                stream.push_back(mk(FLIT_BODY, 16'(p * 16 + k)));
            stream.push_back(mk(FLIT_TAIL, 16'(p * 16 + 15)));
        end
        idx = 0;
        budget = 0;
        tails_q = 0;
        while ((idx < stream.size() || sb.size() != 0) && budget < 2000) begin
            bus.in_enable = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
            bus.in_flit   = (idx < stream.size()) ? stream[idx] : '0;
            bus.out_ack   = ($urandom_range(0, 2) != 0);
            do_push = bus.in_enable && bus.in_ack;
            do_pop  = bus.out_enable && bus.out_ack;
            if (do_pop) begin
                exp_f = sb.pop_front();
                chk("t6_order", 32'(bus.out_flit), 32'(exp_f));
                if (exp_f.ftype == FLIT_TAIL) tails_q--;
            end
            if (do_push) begin
                sb.push_back(stream[idx]);
                if (stream[idx].ftype == FLIT_TAIL) tails_q++;
                idx++;
            end
            cyc();
            chk("t6_occ", 32'(bus.occupancy), 32'(sb.size()));
            chk("t6_pkt", 32'(bus.pkt_count), 32'(tails_q));
            budget++;
        end
        bus.in_enable = 1'b0;
        bus.out_ack = 1'b0;
        chk("t6_done_in_budget", 32'(budget < 2000), 32'd1);
        chk("t6_all_sent", 32'(idx), 32'(stream.size()));
        chk("t6_err0", 32'(bus.proto_err), 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
